// File: rtl/dense_layer_mac_pkg.sv
// Shared definitions for the dense layer: controller state encoding and index-width helper.
package dense_layer_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_ACT  = 2'd2
  } state_t;

  // Select/index fields keep at least one bit even for single-entry layers.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dense_layer_mac_neuron.sv
// One MAC neuron: weight/bias row, accumulator, then bias add, Q-format rescale,
// saturation and optional ReLU into a registered output.
module dense_layer_mac_neuron #(
  parameter int inputNo   = 10,
  parameter int dataWidth = 16,
  parameter int fracBits  = 8,
  parameter int accWidth  = 40,
  parameter int actMode   = 1,
  parameter int idxWidth  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        mac_en,
  input  logic                        act_en,
  input  logic signed [dataWidth-1:0] x,
  input  logic [idxWidth-1:0]         mac_idx,
  input  logic                        we,
  input  logic [idxWidth-1:0]         w_idx,
  input  logic [dataWidth-1:0]        w_data,
  output logic [dataWidth-1:0]        out
);

  localparam logic signed [accWidth-1:0] SAT_MAX =
    {{(accWidth-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};
  localparam logic signed [accWidth-1:0] SAT_MIN =
    {{(accWidth-dataWidth+1){1'b1}}, {(dataWidth-1){1'b0}}};
  localparam logic [dataWidth-1:0] OUT_MAX = {1'b0, {(dataWidth-1){1'b1}}};
  localparam logic [dataWidth-1:0] OUT_MIN = {1'b1, {(dataWidth-1){1'b0}}};

  logic signed [dataWidth-1:0]   weight [inputNo];
  logic signed [dataWidth-1:0]   bias;
  logic signed [accWidth-1:0]    acc;
  logic signed [2*dataWidth-1:0] prod;
  logic signed [accWidth-1:0]    prod_ext;
  logic signed [accWidth-1:0]    bias_ext;
  logic signed [accWidth-1:0]    sum;
  logic signed [accWidth-1:0]    shifted;
  logic [dataWidth-1:0]          act_val;

  // Coefficient storage deliberately has no reset so loaded weights survive rst.
  always_ff @(posedge clk) begin
    if (we) begin
      if (w_idx == idxWidth'(inputNo)) bias <= w_data;
      else                             weight[w_idx] <= w_data;
    end
  end

  assign prod     = x * weight[mac_idx];
  assign prod_ext = {{(accWidth-2*dataWidth){prod[2*dataWidth-1]}}, prod};
  assign bias_ext = {{(accWidth-dataWidth){bias[dataWidth-1]}}, bias};
  assign sum      = acc + (bias_ext <<< fracBits);
  assign shifted  = sum >>> fracBits;

  always_comb begin
    act_val = shifted[dataWidth-1:0];
    if (shifted > SAT_MAX)      act_val = OUT_MAX;
    else if (shifted < SAT_MIN) act_val = OUT_MIN;
    if (actMode == 1 && shifted[accWidth-1]) act_val = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      out <= '0;
    end else begin
      if (clear)       acc <= '0;
      else if (mac_en) acc <= acc + prod_ext;
      if (act_en)      out <= act_val;
    end
  end

endmodule

// File: rtl/dense_layer_mac.sv
// Fully-connected layer: controller, input capture and coefficient write decode around
// neuronNo parallel MAC neurons; result pulse inputNo+1 edges after accept.
module dense_layer_mac
  import dense_layer_mac_pkg::*;
#(
  parameter int inputNo   = 10,
  parameter int neuronNo  = 10,
  parameter int dataWidth = 16,
  parameter int fracBits  = 8,
  parameter int accWidth  = 40,
  parameter int actMode   = 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            go_in_r,
  input  logic [inputNo*dataWidth-1:0]    in,
  output logic                            ready,
  output logic [neuronNo*dataWidth-1:0]   out,
  output logic                            go_out_r,
  input  logic                            w_we,
  input  logic [idx_bits(neuronNo)-1:0]   w_neuron,
  input  logic [$clog2(inputNo+1)-1:0]    w_idx,
  input  logic [dataWidth-1:0]            w_data
);

  localparam int IW = $clog2(inputNo+1);

  state_t                       state;
  logic [IW-1:0]                idx;
  logic [inputNo*dataWidth-1:0] in_reg;
  logic signed [dataWidth-1:0]  x;
  logic                         accept;
  logic                         wr_ok;

  assign accept = go_in_r & ready;
  assign x      = in_reg[idx*dataWidth +: dataWidth];
  assign wr_ok  = w_we & ready & (32'(w_neuron) < neuronNo) & (32'(w_idx) <= inputNo);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ready    <= 1'b1;
      go_out_r <= 1'b0;
      idx      <= '0;
      in_reg   <= '0;
    end else begin
      go_out_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go_in_r) begin
            in_reg <= in;
            idx    <= '0;
            ready  <= 1'b0;
            state  <= ST_MAC;
          end
        end
        ST_MAC: begin
          if (idx == IW'(inputNo-1)) state <= ST_ACT;
          else                       idx   <= idx + 1'b1;
        end
        ST_ACT: begin
          // Result, pulse and readiness all appear together so the next layer can chain.
          go_out_r <= 1'b1;
          ready    <= 1'b1;
          state    <= ST_IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar n = 0; n < neuronNo; n++) begin : g_neuron
    dense_layer_mac_neuron #(
      .inputNo  (inputNo),
      .dataWidth(dataWidth),
      .fracBits (fracBits),
      .accWidth (accWidth),
      .actMode  (actMode),
      .idxWidth (IW)
    ) u_neuron (
      .clk    (clk),
      .rst    (rst),
      .clear  (accept),
      .mac_en (state == ST_MAC),
      .act_en (state == ST_ACT),
      .x      (x),
      .mac_idx(idx),
      .we     (wr_ok && (32'(w_neuron) == n)),
      .w_idx  (w_idx),
      .w_data (w_data),
      .out    (out[n*dataWidth +: dataWidth])
    );
  end

endmodule

// File: tb/tb_dense_layer_mac.sv
// Directed and random checks of dense_layer_mac (ReLU and linear instances) against a plain arithmetic model.
module tb_dense_layer_mac;
  localparam int NI = 10;
  localparam int NN = 10;
  localparam int DW = 16;
  localparam int FB = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              go_in_r;
  logic              w_we;
  logic [NI*DW-1:0]  in_bus;
  logic [3:0]        w_neuron;
  logic [3:0]        w_idx;
  logic [DW-1:0]     w_data;
  logic              ready_r, go_r, ready_l, go_l;
  logic [NN*DW-1:0]  out_r, out_l;

  always #5 clk = ~clk;

  dense_layer_mac #(.inputNo(NI), .neuronNo(NN), .dataWidth(DW), .fracBits(FB),
                    .accWidth(40), .actMode(1)) dut_relu (
    .clk(clk), .rst(rst), .go_in_r(go_in_r), .in(in_bus), .ready(ready_r), .out(out_r),
    .go_out_r(go_r), .w_we(w_we), .w_neuron(w_neuron), .w_idx(w_idx), .w_data(w_data));

  dense_layer_mac #(.inputNo(NI), .neuronNo(NN), .dataWidth(DW), .fracBits(FB),
                    .accWidth(40), .actMode(0)) dut_lin (
    .clk(clk), .rst(rst), .go_in_r(go_in_r), .in(in_bus), .ready(ready_l), .out(out_l),
    .go_out_r(go_l), .w_we(w_we), .w_neuron(w_neuron), .w_idx(w_idx), .w_data(w_data));

  int     errors = 0;
  int     checks = 0;
  longint w_m [NN][NI];
  longint b_m [NN];
  int     in_v [NI];
  int     in_a [NI];
  int     in_b [NI];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Exact integer dot product, then floor rescale, clamp and optional ReLU.
  function automatic logic [15:0] model(input int n, input bit relu);
    longint s;
    longint r;
    s = 0;
    for (int i = 0; i < NI; i++) s += longint'(in_v[i]) * w_m[n][i];
    s += b_m[n] * (longint'(1) << FB);
    r = s >>> FB;
    if (r > 32767) r = 32767;
    else if (r < -32768) r = -32768;
    if (relu && r < 0) r = 0;
    return r[15:0];
  endfunction

  task automatic pack_in();
    for (int i = 0; i < NI; i++) in_bus[i*DW +: DW] = 16'(in_v[i]);
  endtask

  task automatic model_write(input int n, input int i, input logic signed [15:0] v);
    if (n < NN && i <= NI) begin
      if (i == NI) b_m[n] = v;
      else         w_m[n][i] = v;
    end
  endtask

  task automatic wr(input int n, input int i, input int val);
    w_neuron = 4'(n);
    w_idx    = 4'(i);
    w_data   = 16'(val);
    w_we     = 1'b1;
    @(negedge clk);
    w_we = 1'b0;
    model_write(n, i, 16'(val));
  endtask

  task automatic load_all(input int wv, input int bv);
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < NI; i++) wr(n, i, wv);
      wr(n, NI, bv);
    end
  endtask

  task automatic check_outs(input string tag);
    for (int n = 0; n < NN; n++) begin
      check($sformatf("%s relu n%0d", tag, n), out_r[n*DW +: DW], model(n, 1'b1));
      check($sformatf("%s lin n%0d", tag, n), out_l[n*DW +: DW], model(n, 1'b0));
    end
  endtask

  task automatic check_zero(input string tag);
    for (int n = 0; n < NN; n++) begin
      check($sformatf("%s relu zero n%0d", tag, n), out_r[n*DW +: DW], 0);
      check($sformatf("%s lin zero n%0d", tag, n), out_l[n*DW +: DW], 0);
    end
  endtask

  task automatic run_op(input string tag, input bit with_wr = 1'b0,
                        input int wn = 0, input int wi = 0, input int wv = 0);
    int lat;
    pack_in();
    if (with_wr) begin
      w_neuron = 4'(wn);
      w_idx    = 4'(wi);
      w_data   = 16'(wv);
      w_we     = 1'b1;
      model_write(wn, wi, 16'(wv));
    end
    go_in_r = 1'b1;
    @(negedge clk);
    go_in_r = 1'b0;
    w_we    = 1'b0;
    check({tag, " busy"}, ready_r, 0);
    // Input is scrambled after accept; the captured copy must be the one used.
    for (int i = 0; i < NI; i++) in_bus[i*DW +: DW] = 16'($urandom);
    lat = 0;
    while (!go_r && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, 11);
    check({tag, " lin pulse"}, go_l, 1);
    check_outs(tag);
    @(negedge clk);
    check({tag, " pulse width"}, go_r, 0);
    check({tag, " ready after"}, ready_r, 1);
  endtask

  initial begin
    int pulses;
    int cycle;
    int p1;
    int p2;
    for (int n = 0; n < NN; n++) begin
      b_m[n] = 0;
      for (int i = 0; i < NI; i++) w_m[n][i] = 0;
    end
    rst = 1'b1; go_in_r = 1'b0; w_we = 1'b0; in_bus = '0;
    w_neuron = '0; w_idx = '0; w_data = '0;
    repeat (2) @(negedge clk);
    check("reset ready", ready_r, 1);
    check("reset go_out", go_r, 0);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Identity weights
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < NI; i++) wr(n, i, (n == i) ? 256 : 0);
      wr(n, NI, 0);
    end
    for (int i = 0; i < NI; i++) in_v[i] = (i + 1) * 256;
    run_op("identity");
    check("identity n2 const", out_l[2*DW +: DW], 16'h0300);

    // Reset in the middle of MAC (idx 5) aborts without a pulse
    pack_in();
    go_in_r = 1'b1;
    @(negedge clk);
    go_in_r = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midreset ready", ready_r, 1);
    check("midreset go_out", go_r, 0);
    check_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (go_r || go_l) pulses++;
    end
    check("midreset no pulse", pulses, 0);
    check("midreset ready idle", ready_r, 1);
    run_op("retained");

    // Activation: -1.0 weights on 1.0 inputs
    load_all(-256, 0);
    for (int i = 0; i < NI; i++) in_v[i] = 256;
    run_op("activation");
    check("activation lin const", out_l[0 +: DW], 16'hF600);
    check("activation relu const", out_r[0 +: DW], 16'h0000);

    // Saturation at both rails
    load_all(32767, 0);
    for (int i = 0; i < NI; i++) in_v[i] = 32767;
    run_op("sat_pos");
    check("sat_pos const", out_r[DW +: DW], 16'h7FFF);
    load_all(-32768, 0);
    run_op("sat_neg");
    check("sat_neg const", out_l[DW +: DW], 16'h8000);

    // Bias only, plus out-of-range writes that must be dropped
    for (int n = 0; n < NN; n++) begin
      for (int i = 0; i < NI; i++) wr(n, i, 0);
      wr(n, NI, n * 256);
    end
    wr(12, 0, 16'h1234);
    wr(3, 11, 16'h1234);
    wr(15, NI, 16'h4000);
    for (int i = 0; i < NI; i++) in_v[i] = int'($urandom_range(65535)) - 32768;
    run_op("bias");
    check("bias n7 const", out_r[7*DW +: DW], 16'h0700);

    // Back-to-back with go_in_r held, input change mid-MAC and a dropped busy write
    for (int n = 0; n < NN; n++) for (int i = 0; i < NI; i++)
      wr(n, i, int'($urandom_range(1023)) - 512);
    for (int i = 0; i < NI; i++) begin
      in_a[i] = int'($urandom_range(65535)) - 32768;
      in_b[i] = int'($urandom_range(65535)) - 32768;
    end
    in_v = in_a;
    pack_in();
    go_in_r = 1'b1;
    cycle = 0; pulses = 0; p1 = 0; p2 = 0;
    while (pulses < 2 && cycle < 60) begin
      @(negedge clk);
      cycle++;
      if (cycle == 3) begin
        w_neuron = 4'd0; w_idx = 4'd0; w_data = 16'h7000; w_we = 1'b1;
      end
      if (cycle == 4) w_we = 1'b0;
      if (cycle == 5) begin
        in_v = in_b;
        pack_in();
      end
      if (go_r) begin
        pulses++;
        if (pulses == 1) begin
          p1 = cycle;
          in_v = in_a;
          check_outs("b2b first");
          in_v = in_b;
        end else begin
          p2 = cycle;
          check_outs("b2b second");
          go_in_r = 1'b0;
        end
      end
    end
    go_in_r = 1'b0;
    check("b2b pulses", pulses, 2);
    check("b2b first latency", p1, 12);
    // Second accept is the edge right after the first pulse, then 11 more edges.
    check("b2b spacing", p2 - p1, 12);
    @(negedge clk);
    check("b2b idle ready", ready_r, 1);
    check("b2b no third", go_r, 0);

    // Random weights/biases/inputs; last bias write coincides with accept
    for (int t = 0; t < 3; t++) begin
      for (int n = 0; n < NN; n++) begin
        for (int i = 0; i < NI; i++) wr(n, i, int'($urandom_range(1023)) - 512);
        if (n < NN - 1) wr(n, NI, int'($urandom_range(65535)) - 32768);
      end
      for (int i = 0; i < NI; i++) in_v[i] = int'($urandom_range(65535)) - 32768;
      run_op($sformatf("random%0d", t), 1'b1, NN - 1, NI, int'($urandom_range(65535)) - 32768);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
